contador_etapas: RTL and testbench

- Parametrised instruction step counter for the processor control unit; successor to the fixed 2-bit Tstep counter.
- Supports a configurable number of steps and a per-instruction step count. Adds stall (Hold), a completion pulse (Done), a one-hot step output and overrun detection.
- Sits between the control-unit FSM/decoder and the datapath enables; the decoder supplies the last step of the current instruction.

---
 rtl/contador_etapas_pkg.sv | 7 +
 rtl/detector_borda.sv | 13 +
 rtl/contador_etapas.sv | 86 ++++++++
 tb/tb_contador_etapas.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/contador_etapas_pkg.sv
// contador_etapas_pkg: shared control-unit constants for the step counter and decoder.
package contador_etapas_pkg;
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;
  localparam int DEF_NSTEPS = 8;
  localparam int DEF_STEP_W = 3;
endpackage

// File: rtl/detector_borda.sv
// detector_borda: registered rising-edge detector; pulse is high while in is high and was low last edge.
module detector_borda (
  input  logic Clock,
  input  logic Resetn,
  input  logic in_i,
  output logic pulse_o
);
  logic in_q;
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) in_q <= 1'b0;
    else         in_q <= in_i;
  assign pulse_o = in_i & ~in_q;
endmodule

// File: rtl/contador_etapas.sv
// contador_etapas: parametrised instruction step counter with hold, done pulse, one-hot step and overrun flag.
module contador_etapas
  import contador_etapas_pkg::*;
#(
  parameter int NSTEPS       = DEF_NSTEPS,
  parameter int STEP_W       = DEF_STEP_W,
  parameter int AUTO_RESTART = 1
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Run,
  input  logic              Clear,
  input  logic              Hold,
  input  logic [STEP_W-1:0] LastStep,
  output logic [STEP_W-1:0] Tstep,
  output logic [NSTEPS-1:0] Tstep_oh,
  output logic              Busy,
  output logic              Done,
  output logic              Error
);
  localparam logic [STEP_W-1:0] LAST_IDX = STEP_W'(NSTEPS - 1);
  logic              start;
  logic [0:0]        state_q, state_d;
  logic [STEP_W-1:0] tstep_q, tstep_d;
  logic [NSTEPS-1:0] oh_q, oh_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              complete;
  detector_borda u_borda (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .in_i    (Run),
    .pulse_o (start)
  );
  // LastStep beyond the last index never matches, so the overrun rule terminates it
  always_comb begin
    state_d  = state_q;
    tstep_d  = tstep_q;
    done_d   = 1'b0;
    error_d  = error_q;
    complete = 1'b0;
    if (state_q == ST_IDLE) begin
      tstep_d = '0;
      state_d = start ? ST_ACTIVE : ST_IDLE;
    end else if (Clear) begin
      complete = 1'b1;
    end else if (!Hold) begin
      if (tstep_q == LastStep) begin
        complete = 1'b1;
      end else if (tstep_q == LAST_IDX) begin
        complete = 1'b1;
        error_d  = 1'b1;
      end else begin
        tstep_d = tstep_q + STEP_W'(1);
      end
    end
    if (complete) begin
      tstep_d = '0;
      done_d  = 1'b1;
      state_d = (AUTO_RESTART != 0 && Run) ? ST_ACTIVE : ST_IDLE;
    end
  end
  always_comb begin
    oh_d = '0;
    for (int i = 0; i < NSTEPS; i++) oh_d[i] = (tstep_d == STEP_W'(i));
  end
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) begin
      state_q <= ST_IDLE;
      tstep_q <= '0;
      oh_q    <= NSTEPS'(1);
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tstep_q <= tstep_d;
      oh_q    <= oh_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  assign Tstep    = tstep_q;
  assign Tstep_oh = oh_q;
  assign Busy     = (state_q == ST_ACTIVE);
  assign Done     = done_q;
  assign Error    = error_q;
endmodule

// File: tb/tb_contador_etapas.sv
// tb_contador_etapas: three configurations driven in parallel and checked against a step-level reference model.
module tb_contador_etapas;
  logic Clock, Resetn, Run, Clear, Hold;
  logic [2:0] Last;
  logic [2:0] t0, t1, t2;
  logic [7:0] oh0, oh1;
  logic [5:0] oh2;
  logic [2:0] busy, done, err;
  int vectors = 0, miscompares = 0;
  int ns[3] = '{8, 8, 6};
  int ar[3] = '{1, 0, 1};
  int m_step[3];
  bit m_act[3], m_done[3], m_err[3], m_rund;
  contador_etapas #(.NSTEPS(8), .STEP_W(3), .AUTO_RESTART(1)) dut0 (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .Clear(Clear), .Hold(Hold), .LastStep(Last),
    .Tstep(t0), .Tstep_oh(oh0), .Busy(busy[0]), .Done(done[0]), .Error(err[0]));
  contador_etapas #(.NSTEPS(8), .STEP_W(3), .AUTO_RESTART(0)) dut1 (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .Clear(Clear), .Hold(Hold), .LastStep(Last),
    .Tstep(t1), .Tstep_oh(oh1), .Busy(busy[1]), .Done(done[1]), .Error(err[1]));
  contador_etapas #(.NSTEPS(6), .STEP_W(3), .AUTO_RESTART(1)) dut2 (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .Clear(Clear), .Hold(Hold), .LastStep(Last),
    .Tstep(t2), .Tstep_oh(oh2), .Busy(busy[2]), .Done(done[2]), .Error(err[2]));
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;
  function automatic logic [13:0] obs_vec(int k);
    case (k)
      0:       return {t0, oh0, busy[0], done[0], err[0]};
      1:       return {t1, oh1, busy[1], done[1], err[1]};
      default: return {t2, 2'b00, oh2, busy[2], done[2], err[2]};
    endcase
  endfunction
  function automatic logic [13:0] exp_vec(int k);
    logic [7:0] oh;
    oh = 8'(1 << m_step[k]);
    return {3'(m_step[k]), oh, m_act[k], m_done[k], m_err[k]};
  endfunction
  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_step[k] = 0; m_act[k] = 0; m_done[k] = 0; m_err[k] = 0;
    end
    m_rund = 0;
  endtask
  task automatic model_step();
    bit start, fin;
    start = Run && !m_rund;
    for (int k = 0; k < 3; k++) begin
      fin = 0;
      m_done[k] = 0;
      if (!m_act[k]) begin
        m_step[k] = 0;
        m_act[k] = start;
      end else if (Clear) fin = 1;
      else if (Hold) fin = 0;
      else if (m_step[k] == int'(Last)) fin = 1;
      else if (m_step[k] == ns[k] - 1) begin
        fin = 1;
        m_err[k] = 1;
      end else m_step[k]++;
      if (fin) begin
        m_step[k] = 0;
        m_done[k] = 1;
        m_act[k] = (ar[k] != 0) && Run;
      end
    end
    m_rund = Run;
  endtask
  task automatic tick();
    @(posedge Clock);
    if (!Resetn) model_reset();
    else model_step();
    @(negedge Clock);
  endtask
  task automatic test_reset();
    Resetn = 0; Run = 0; Clear = 0; Hold = 0; Last = 0;
    model_reset();
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (obs_vec(k) !== exp_vec(k)) begin
        miscompares++;
        $display("FAIL reset dut%0d got %h expected %h", k, obs_vec(k), exp_vec(k));
      end
    end
    Resetn = 1;
  endtask
  task automatic test_auto_restart();
    Last = 3; Run = 1;
    for (int c = 0; c < 12; c++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (obs_vec(k) !== exp_vec(k)) begin
          miscompares++;
          $display("FAIL auto_restart c%0d dut%0d got %h expected %h", c, k, obs_vec(k), exp_vec(k));
        end
      end
    end
  endtask
  task automatic test_single_pass();
    Run = 0; Clear = 1;
    tick(); tick();
    Clear = 0; Last = 2; Run = 1;
    for (int c = 0; c < 14; c++) begin
      if (c == 1) Run = 1;
      if (c == 9) Run = 0;
      if (c == 10) Run = 1;
      tick();
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (obs_vec(k) !== exp_vec(k)) begin
          miscompares++;
          $display("FAIL single_pass c%0d dut%0d got %h expected %h", c, k, obs_vec(k), exp_vec(k));
        end
      end
    end
  endtask
  task automatic test_hold_clear();
    Run = 0; Clear = 1;
    tick(); tick();
    Clear = 0; Last = 7; Run = 1;
    for (int c = 0; c < 7; c++) begin
      Hold = (c >= 2);
      Clear = (c == 5);
      tick();
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (obs_vec(k) !== exp_vec(k)) begin
          miscompares++;
          $display("FAIL hold_clear c%0d dut%0d got %h expected %h", c, k, obs_vec(k), exp_vec(k));
        end
      end
    end
    Hold = 0; Clear = 0;
  endtask
  task automatic test_overrun();
    Last = 7; Run = 1;
    for (int c = 0; c < 20; c++) begin
      if (c == 14) Last = 1;
      tick();
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (obs_vec(k) !== exp_vec(k)) begin
          miscompares++;
          $display("FAIL overrun c%0d dut%0d got %h expected %h", c, k, obs_vec(k), exp_vec(k));
        end
      end
    end
  endtask
  task automatic test_run_reedge();
    Run = 0; Clear = 1;
    tick();
    Clear = 0; Last = 5; Run = 1;
    for (int c = 0; c < 9; c++) begin
      if (c == 3) Run = 0;
      if (c == 4) Run = 1;
      tick();
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (obs_vec(k) !== exp_vec(k)) begin
          miscompares++;
          $display("FAIL run_reedge c%0d dut%0d got %h expected %h", c, k, obs_vec(k), exp_vec(k));
        end
      end
    end
  endtask
  task automatic test_async_reset();
    Run = 0; Clear = 1;
    tick();
    Clear = 0; Last = 6; Run = 1;
    tick(); tick(); tick();
    #2 Resetn = 0;
    #1 model_reset();
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (obs_vec(k) !== exp_vec(k)) begin
        miscompares++;
        $display("FAIL async_reset dut%0d got %h expected %h", k, obs_vec(k), exp_vec(k));
      end
    end
    tick();
    Resetn = 1; Run = 0;
    tick();
  endtask
  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      Run   = ($urandom_range(0, 5) != 0);
      Clear = ($urandom_range(0, 9) == 0);
      Hold  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) Last = 3'($urandom_range(0, 7));
      tick();
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (obs_vec(k) !== exp_vec(k)) begin
          miscompares++;
          $display("FAIL random c%0d dut%0d got %h expected %h", c, k, obs_vec(k), exp_vec(k));
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_auto_restart();
    test_single_pass();
    test_hold_clear();
    test_overrun();
    test_run_reedge();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
